// File: rtl/mem_responder.sv
// mem_responder: bridges core load/store requests onto a single-port 32-bit
// data SRAM with a one-cycle read latency. Stores complete in one cycle;
// aligned loads stall the core for two cycles (IDLE -> RD_WAIT -> RESP).
// Misaligned or illegal accesses raise a registered one-cycle misalign pulse
// and clear rdata, without touching the SRAM.
module mem_responder #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_store, is_load, st_legal, ld_legal, aligned;
  logic        st_ok, ld_ok, bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;

  // Address bits above the SRAM window are deliberately dropped (wrap-around).
  logic        unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign ram_addr = addr[ADDR_W+1:2];

  // Request decode; a simultaneous read+write request is treated as a store.
  always_comb begin
    is_store = MemWrite;
    is_load  = MemRead & ~MemWrite;
    st_legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
    ld_legal = st_legal || (funct3 == 3'd4) || (funct3 == 3'd5);
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    st_ok = is_store & st_legal & aligned;
    ld_ok = is_load & ld_legal & aligned;
    bad   = (is_store | is_load) & ~st_ok & ~ld_ok;
  end

  // SRAM strobes and core stall; everything is held inactive during reset.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_wdata = wdata;
    stall     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (st_ok) begin
            ram_en = 1'b1;
            case (funct3[1:0])
              2'b00: begin
                ram_we    = 4'b0001 << addr[1:0];
                ram_wdata = {4{wdata[7:0]}};
              end
              2'b01: begin
                ram_we    = addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{wdata[15:0]}};
              end
              default: begin
                ram_we    = 4'b1111;
                ram_wdata = wdata;
              end
            endcase
          end else if (ld_ok) begin
            ram_en = 1'b1;
            stall  = 1'b1;
          end
        end
        RD_WAIT: stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Lane selection and sign/zero extension of the returning SRAM word.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = ram_rdata[7:0];
      2'd1:    lane_b = ram_rdata[15:8];
      2'd2:    lane_b = ram_rdata[23:16];
      default: lane_b = ram_rdata[31:24];
    endcase
    lane_h = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      3'd0:    ld_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    ld_val = {{16{lane_h[15]}}, lane_h};
      3'd4:    ld_val = {24'd0, lane_b};
      3'd5:    ld_val = {16'd0, lane_h};
      default: ld_val = ram_rdata;
    endcase
  end

  // FSM, captured load attributes, result register and misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdata    <= '0;
      misalign <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (bad) begin
            misalign <= 1'b1;
            rdata    <= '0;
          end else if (ld_ok) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata <= ld_val;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a byte-addressed reference memory
// predicts load results and store lane strobes; a simple SRAM model with
// one-cycle read latency sits on the RAM port.
module tb_mem_responder;

  localparam int AW    = 8;
  localparam int NBYTE = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          MemRead, MemWrite;
  logic [2:0]    funct3;
  logic [31:0]   addr, wdata, rdata;
  logic          stall, misalign, ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  int passed = 0;
  int total  = 0;

  bit   [31:0] sram [0:(1<<AW)-1];
  logic [7:0]  refm [0:NBYTE-1];
  logic [31:0] last_rdata;

  mem_responder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= sram[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd2) return 4;
    if (f3[1:0] == 2'd1) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned v = 0;
    int sz = acc_size(f3);
    for (int k = 0; k < sz; k++) v = v + (int'(refm[(a + k) % NBYTE]) << (8 * k));
    if (f3 == 3'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [AW-1:0] exp_waddr(input logic [31:0] a);
    return AW'((a / 4) % (1 << AW));
  endfunction

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic both);
    logic [3:0]  ewe = '0;
    logic [31:0] ewd;
    int sz = acc_size(f3);
    for (int k = 0; k < sz; k++) ewe[(a % 4) + k] = 1'b1;
    ewd = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
    MemWrite = 1'b1; MemRead = both; funct3 = f3; addr = a; wdata = d;
    @(negedge clk);
    total++; if (ram_en !== 1'b1) $display("FAIL st_en: got %b want 1", ram_en); else passed++;
    total++; if (ram_we !== ewe) $display("FAIL st_we: got %b want %b", ram_we, ewe); else passed++;
    total++; if (ram_wdata !== ewd) $display("FAIL st_wdata: got %h want %h", ram_wdata, ewd); else passed++;
    total++; if (ram_addr !== exp_waddr(a)) $display("FAIL st_addr: got %h want %h", ram_addr, exp_waddr(a)); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL st_stall: got %b want 0", stall); else passed++;
    total++; if (rdata !== last_rdata) $display("FAIL st_rdata_hold: got %h want %h", rdata, last_rdata); else passed++;
    for (int k = 0; k < sz; k++) refm[(a + k) % NBYTE] = d[8*k +: 8];
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = f3; addr = a;
    @(negedge clk);
    total++; if (ram_en !== 1'b1 || ram_we !== 4'b0) $display("FAIL ld_req: got en=%b we=%b want en=1 we=0", ram_en, ram_we); else passed++;
    total++; if (stall !== 1'b1) $display("FAIL ld_stall_n: got %b want 1", stall); else passed++;
    total++; if (ram_addr !== exp_waddr(a)) $display("FAIL ld_addr: got %h want %h", ram_addr, exp_waddr(a)); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (stall !== 1'b1 || ram_en !== 1'b0) $display("FAIL ld_wait: got stall=%b en=%b want stall=1 en=0", stall, ram_en); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL ld_resp: got stall=%b en=%b want stall=0 en=0", stall, ram_en); else passed++;
    total++; if (rdata !== exp) $display("FAIL ld_data f3=%0d a=%h: got %h want %h", f3, a, rdata, exp); else passed++;
    last_rdata = exp;
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL ld_after: got stall=%b en=%b want 0 0", stall, ram_en); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic do_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    MemWrite = st; MemRead = ~st; funct3 = f3; addr = a; wdata = $urandom;
    @(negedge clk);
    total++; if (ram_en !== 1'b0 || ram_we !== 4'b0 || stall !== 1'b0)
      $display("FAIL bad_req: got en=%b we=%b stall=%b want 0 0000 0", ram_en, ram_we, stall); else passed++;
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    total++; if (misalign !== 1'b1) $display("FAIL bad_pulse: got %b want 1", misalign); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL bad_rdata: got %h want 0", rdata); else passed++;
    last_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (misalign !== 1'b0) $display("FAIL bad_end: got %b want 0", misalign); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; addr = 32'h10; wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (stall !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'b0)
      $display("FAIL rst_outs: got stall=%b en=%b we=%b want 0 0 0000", stall, ram_en, ram_we); else passed++;
    total++; if (rdata !== 32'h0 || misalign !== 1'b0)
      $display("FAIL rst_regs: got rdata=%h mis=%b want 0 0", rdata, misalign); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    total++; if (stall !== 1'b0 || rdata !== 32'h0) $display("FAIL rst_idle: got stall=%b rdata=%h want 0 0", stall, rdata); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw;
    do_store(3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    do_load(3'd2, 32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_extension;
    do_store(3'd2, 32'h20, 32'h80F07F01, 1'b0);
    do_load(3'd0, 32'h23, 32'hFFFFFF80);
    do_load(3'd4, 32'h23, 32'h00000080);
    do_load(3'd1, 32'h22, 32'hFFFF80F0);
    do_load(3'd5, 32'h22, 32'h000080F0);
    do_load(3'd0, 32'h20, 32'h00000001);
  endtask

  task automatic test_sb_merge;
    do_store(3'd2, 32'h30, 32'h11223344, 1'b0);
    do_store(3'd0, 32'h31, 32'h000000AA, 1'b0);
    do_load(3'd2, 32'h30, 32'h1122AA44);
  endtask

  task automatic test_misalign;
    do_load(3'd2, 32'h10, 32'hDEADBEEF);
    do_bad(1'b0, 3'd2, 32'h42);
    do_bad(1'b1, 3'd1, 32'h43);
    do_bad(1'b0, 3'd3, 32'h40);
    do_bad(1'b1, 3'd4, 32'h40);
    do_load(3'd2, 32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_reset_rdwait;
    MemRead = 1'b1; funct3 = 3'd2; addr = 32'h20;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL rw_rst_outs: got stall=%b en=%b want 0 0", stall, ram_en); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    total++; if (rdata !== 32'h0 || stall !== 1'b0) $display("FAIL rw_abort: got rdata=%h stall=%b want 0 0", rdata, stall); else passed++;
    @(posedge clk); #1;
    do_load(3'd2, 32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_both;
    do_store(3'd2, 32'h8, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL both_noread: got stall=%b en=%b want 0 0", stall, ram_en); else passed++;
    @(posedge clk); #1;
    do_load(3'd2, 32'h8, 32'hCAFEF00D);
  endtask

  task automatic test_random;
    for (int n = 0; n < 120; n++) begin
      int          kind = $urandom_range(0, 2);
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom & 32'hFFFF_F03F;
      int          sz   = acc_size(f3);
      logic        al;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 1);
      al = (a % sz) == 0;
      if (kind == 1) begin
        if (al && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) do_load(f3, a, ref_load(f3, a));
        else do_bad(1'b0, f3, a);
      end else begin
        if (al && f3 <= 3'd2) do_store(f3, a, $urandom, kind == 2);
        else do_bad(1'b1, f3, a);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NBYTE; i++) refm[i] = 8'h00;
    last_rdata = '0;
    test_reset;
    test_sw_lw;
    test_extension;
    test_sb_merge;
    test_misalign;
    test_reset_rdwait;
    test_both;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d checks want completion", total);
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 14, the word-address width of the attached data SRAM (2^ADDR_W 32-bit words).
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 MemRead  input  1  load request from the core controller; level, held until the access completes.
REQ-005 MemWrite  input  1  store request from the core controller; level.
REQ-006 funct3  input  3  access size/sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu for loads; 0 sb, 1 sh, 2 sw for stores.
REQ-007 addr  input  32  byte address from the ALU result.
REQ-008 wdata  input  32  store data; the low byte or half-word is used for sb and sh.
REQ-009 rdata  output  32  load result, extended per funct3.
REQ-010 stall  output  1  core hold request; the core SHALL NOT advance its PC or pipeline while this is high.
REQ-011 misalign  output  1  one-cycle pulse flagging a misaligned or illegal access.
REQ-012 ram_en  output  1  SRAM access strobe.
REQ-013 ram_we  output  4  SRAM byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-014 ram_addr  output  ADDR_W  SRAM word address, taken from addr[ADDR_W+1:2].
REQ-015 ram_wdata  output  32  SRAM write data, lane-replicated.
REQ-016 ram_rdata  input  32  SRAM read data, valid exactly one cycle after a read strobe (ram_en=1, ram_we=0).

Function
REQ-017 The FSM SHALL have three states: IDLE, RD_WAIT and RESP.
REQ-018 Alignment: a half-word access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]!=0; funct3 values 3, 6 and 7 are illegal for loads; funct3 values other than 0-2 are illegal for stores.
REQ-019 Store in IDLE, aligned and legal: in the same cycle, ram_en=1 and ram_we = 0001<<addr[1:0] for sb, 0011<<addr[1] *2 lanes for sh, 1111 for sw; ram_wdata = {4{wdata[7:0]}} for sb, {2{wdata[15:0]}} for sh, wdata for sw; stall=0; the FSM SHALL remain in IDLE, so stores take one cycle.
REQ-020 Load in IDLE, aligned and legal: ram_en=1, ram_we=0, stall=1; capture funct3 and addr[1:0]; next state RD_WAIT.
REQ-021 RD_WAIT: ram_en=0, stall=1; register the lane-selected and extended ram_rdata into rdata; next state RESP.
REQ-022 RESP: stall=0, rdata holds the result, ram_en=0; any MemRead or MemWrite in this cycle belongs to the completing instruction and SHALL be ignored; next state IDLE.
REQ-023 Load latency: the request appears in cycle N; rdata is valid and stall=0 in cycle N+2; the core retires the load at the end of cycle N+2.
REQ-024 Extension: lb/lh sign-extend from bit 7/15 of the selected lane; lbu/lhu zero-extend; byte lane = addr[1:0]; half lane = addr[1].
REQ-025 A misaligned or illegal access in IDLE SHALL produce: misalign=1 for one cycle; no SRAM access (ram_en=0, ram_we=0); stall=0; rdata=0; the FSM stays in IDLE.
REQ-026 MemRead and MemWrite both high in IDLE: the request SHALL be treated as a store; the read SHALL be discarded.
REQ-027 Address bits above ADDR_W+1 SHALL be ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
REQ-028 No request in IDLE: ram_en=0, ram_we=0, stall=0, and rdata holds its last value.
REQ-029 ram_we SHALL be nonzero only in IDLE during an aligned, legal store.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=IDLE, rdata=0, misalign=0 and clear the captured funct3 and offset; while rst is high, stall, ram_en and ram_we SHALL be 0.
REQ-031 Reset asserted in RD_WAIT or RESP SHALL abort the load: no rdata update; the next request after reset starts fresh from IDLE.

Verification
REQ-032 sw addr=0x10, wdata=0xDEADBEEF, then lw addr=0x10 -> ram_we=1111 and ram_addr=4 in the store cycle; stall=1 for 2 cycles; rdata=0xDEADBEEF in RESP.
REQ-033 Memory word 0x80F0_7F01 at addr 0x20; lb 0x23, lbu 0x23, lh 0x22, lhu 0x22, lb 0x20 -> rdata = 0xFFFFFF80, 0x00000080, 0xFFFF80F0, 0x000080F0, 0x00000001.
REQ-034 sb addr=0x31, wdata=0x000000AA over word 0x11223344 -> ram_we=0010, ram_wdata=0xAAAAAAAA; a subsequent lw returns 0x1122AA44.
REQ-035 lw addr=0x42; sh addr=0x43; load with funct3=3 -> each pulses misalign=1 for one cycle with ram_en=0, stall=0 and no state change.
REQ-036 rst raised in the RD_WAIT cycle of lw -> next cycle state=IDLE, rdata=0, stall=0; a new lw completes normally with 2-cycle stall.
REQ-037 MemRead=MemWrite=1 with funct3=2 at addr 0x8 -> a single-cycle store with ram_we=1111 and no stall.
